// File: rtl/rsi_algo.sv
// RSI threshold-signal generator: clamps each sample, then a confirm/hysteresis FSM
// drives level signals for oversold (out1) and overbought (out2).
`timescale 1ns/1ps
module rsi_algo #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned RSI_MAX = 100,
    parameter int unsigned LOW_TH  = 30,
    parameter int unsigned HIGH_TH = 70,
    parameter int unsigned HYST    = 5,
    parameter int unsigned CONFIRM = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] rsi_,
    output logic             out1,
    output logic             out2
);

    localparam int unsigned EW = WIDTH + 1;

    // One guard bit so the exit thresholds can never wrap.
    localparam logic [WIDTH:0] MAX_X     = EW'(RSI_MAX);
    localparam logic [WIDTH:0] LOW_X     = EW'(LOW_TH);
    localparam logic [WIDTH:0] HIGH_X    = EW'(HIGH_TH);
    localparam logic [WIDTH:0] LOW_EXIT  = EW'(LOW_TH) + EW'(HYST);
    localparam logic [WIDTH:0] HIGH_EXIT = (HIGH_TH > HYST) ? EW'(HIGH_TH - HYST) : '0;
    localparam logic [7:0]     CONF_C    = 8'(CONFIRM);
    localparam bit             CONF_ONE  = (CONFIRM == 1);

    if (LOW_EXIT > HIGH_EXIT) begin : g_bad_band
        $error("rsi_algo: LOW_TH+HYST must not exceed HIGH_TH-HYST");
    end
    if (CONFIRM < 1 || CONFIRM > 255) begin : g_bad_confirm
        $error("rsi_algo: CONFIRM must be in 1..255");
    end

    typedef enum logic [2:0] {
        NEUTRAL,
        PEND_LOW,
        OVERSOLD,
        PEND_HIGH,
        OVERBOUGHT
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] r_rsi_q, r_rsi_d;
    logic [7:0]       cnt_q, cnt_d, cnt_inc;
    logic             out1_q, out2_q;

    logic [WIDTH:0]   rsi_x;
    logic             below, above;
    state_e           start_low, start_high;

    assign r_rsi_d    = ({1'b0, rsi_} > MAX_X) ? MAX_X[WIDTH-1:0] : rsi_;
    assign rsi_x      = {1'b0, r_rsi_q};
    assign below      = rsi_x < LOW_X;
    assign above      = rsi_x > HIGH_X;
    assign cnt_inc    = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
    assign start_low  = CONF_ONE ? OVERSOLD : PEND_LOW;
    assign start_high = CONF_ONE ? OVERBOUGHT : PEND_HIGH;

    always_comb begin
        // NOTE: defaults first so every path assigns every output -- no latches.
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            NEUTRAL: begin
                if (below) begin
                    state_d = start_low;
                    cnt_d   = 8'd1;
                end else if (above) begin
                    state_d = start_high;
                    cnt_d   = 8'd1;
                end
            end
            PEND_LOW: begin
                if (below) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CONF_C) state_d = OVERSOLD;
                end else if (above) begin
                    state_d = start_high;
                    cnt_d   = 8'd1;
                end else begin
                    state_d = NEUTRAL;
                    cnt_d   = 8'd0;
                end
            end
            PEND_HIGH: begin
                if (above) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CONF_C) state_d = OVERBOUGHT;
                end else if (below) begin
                    state_d = start_low;
                    cnt_d   = 8'd1;
                end else begin
                    state_d = NEUTRAL;
                    cnt_d   = 8'd0;
                end
            end
            OVERSOLD: begin
                if (rsi_x >= LOW_EXIT) begin
                    // A jump straight past the overbought line restarts confirmation there.
                    if (above) begin
                        state_d = start_high;
                        cnt_d   = 8'd1;
                    end else begin
                        state_d = NEUTRAL;
                        cnt_d   = 8'd0;
                    end
                end
            end
            OVERBOUGHT: begin
                if (rsi_x <= HIGH_EXIT) begin
                    if (below) begin
                        state_d = start_low;
                        cnt_d   = 8'd1;
                    end else begin
                        state_d = NEUTRAL;
                        cnt_d   = 8'd0;
                    end
                end
            end
            default: begin
                state_d = NEUTRAL;
                cnt_d   = 8'd0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsi_q <= '0;
            cnt_q   <= '0;
            state_q <= NEUTRAL;
            out1_q  <= 1'b0;
            out2_q  <= 1'b0;
        end else begin
            r_rsi_q <= r_rsi_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            out1_q  <= (state_d == OVERSOLD);
            out2_q  <= (state_d == OVERBOUGHT);
        end
    end

    assign out1 = out1_q;
    assign out2 = out2_q;

endmodule

// File: tb/tb_rsi_algo.sv
// Directed, table-driven bench for rsi_algo with default parameters (CONFIRM=2).
`timescale 1ns/1ps
module tb_rsi_algo;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] rsi_;
    logic         out1, out2;

    int checks   = 0;
    int failures = 0;

    rsi_algo #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rsi_  (rsi_),
        .out1  (out1),
        .out2  (out2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] rsi;
        logic         o1;
        logic         o2;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [W-1:0] r, input logic e1, input logic e2, input int n = 1);
        vec_t v;
        v.rsi = r;
        v.o1  = e1;
        v.o2  = e2;
        for (int k = 0; k < n; k++) vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic e1, input logic e2);
        checks++;
        if (out1 !== e1 || out2 !== e2) begin
            failures++;
            $display("FAIL %s: got out1=%b out2=%b, expected out1=%b out2=%b",
                     name, out1, out2, e1, e2);
        end
    endtask

    // Drive rsi_ ahead of the next rising edge, then check just after it.
    task automatic apply(input logic [W-1:0] r, input string name, input logic e1, input logic e2);
        @(negedge clk);
        rsi_ = r;
        @(posedge clk);
        #1;
        check(name, e1, e2);
    endtask

    // out1 and out2 must never be high together, in any scenario.
    always @(negedge clk) begin
        checks++;
        if ((out1 & out2) !== 1'b0) begin
            failures++;
            $display("FAIL mutex: got out1=%b out2=%b, expected not both 1", out1, out2);
        end
    end

    initial begin
        rst_n = 1'b0;
        rsi_  = 32'd10;

        // Oversold entry, hysteresis hold, exit after 2 edges.
        add(32'd50, 0, 0);
        add(32'd20, 0, 0, 2);
        add(32'd20, 1, 0);
        add(32'd33, 1, 0, 3);
        add(32'd35, 1, 0);
        add(32'd35, 0, 0, 2);
        // Clamp to 100 and overbought, hysteresis at 66, exit at 65.
        add(32'hFFFF_FFFF, 0, 0, 2);
        add(32'hFFFF_FFFF, 0, 1);
        add(32'd66, 0, 1, 3);
        add(32'd65, 0, 1);
        add(32'd65, 0, 0, 2);
        // Exact thresholds never qualify.
        add(32'd30, 0, 0, 10);
        add(32'd70, 0, 0, 10);
        // 29 enters oversold; 71 swings straight to overbought.
        add(32'd29, 0, 0, 2);
        add(32'd29, 1, 0);
        add(32'd71, 1, 0);
        add(32'd71, 0, 0);
        add(32'd71, 0, 1);
        add(32'd50, 0, 1);
        add(32'd50, 0, 0, 2);
        // Single-sample spike is rejected.
        add(32'd20, 0, 0);
        add(32'd50, 0, 0, 4);
        // Low spike then sustained high: only out2.
        add(32'd20, 0, 0);
        add(32'd80, 0, 0, 2);
        add(32'd80, 0, 1, 2);
        add(32'd50, 0, 1);
        add(32'd50, 0, 0, 2);
        // Direct swing from oversold to overbought.
        add(32'd20, 0, 0, 2);
        add(32'd20, 1, 0);
        add(32'd90, 1, 0);
        add(32'd90, 0, 0);
        add(32'd90, 0, 1, 2);

        // Reset held across many edges with an oversold input.
        repeat (6) begin
            @(posedge clk);
            #1;
            check("reset_hold", 1'b0, 1'b0);
        end
        @(negedge clk);
        rsi_  = 32'd50;
        rst_n = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
            check("post_reset_idle", 1'b0, 1'b0);
        end

        for (int i = 0; i < vecs.size(); i++)
            apply(vecs[i].rsi, $sformatf("vec%0d_rsi%0d", i, vecs[i].rsi), vecs[i].o1, vecs[i].o2);

        // Asynchronous reset while OVERSOLD drops out1 with no clock edge.
        apply(32'd50, "pre_async_a", 1'b0, 1'b1);
        apply(32'd50, "pre_async_b", 1'b0, 1'b0);
        apply(32'd20, "pre_async_c", 1'b0, 1'b0);
        apply(32'd20, "pre_async_d", 1'b0, 1'b0);
        apply(32'd20, "pre_async_os", 1'b1, 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_drop", 1'b0, 1'b0);
        repeat (3) begin
            @(posedge clk);
            #1;
            check("async_reset_hold", 1'b0, 1'b0);
        end
        @(negedge clk);
        rsi_  = 32'd50;
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            check("async_reset_release", 1'b0, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rsi_algo.md
Name: rsi_algo

Overview:
- Threshold-signal generator for the HFT pipeline.
- Consumes a precomputed RSI sample every clock and raises out1 (oversold/buy) or out2 (overbought/sell).
- Uses a confirmation count to reject single-sample spikes and a hysteresis band to prevent chatter at the thresholds.
- Sits between the indicator stage and order-decision logic; outputs are level signals.

Parameters:
- WIDTH, 32, bit width of rsi_
- RSI_MAX, 100, clamp ceiling for the RSI input
- LOW_TH, 30, oversold entry threshold (strictly below)
- HIGH_TH, 70, overbought entry threshold (strictly above)
- HYST, 5, hysteresis margin for exiting an active state
- CONFIRM, 2, consecutive qualifying samples needed to enter a state (legal range 1..255)

Ports:
- clk  input  1  system clock, rising-edge
- rst_n  input  1  asynchronous active-low reset
- rsi_  input  WIDTH  unsigned integer RSI sample, sampled every cycle
- out1  output  1  oversold/buy signal, level
- out2  output  1  overbought/sell signal, level

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset: assertion immediately clears r_rsi, the counter and the state (NEUTRAL), and drives out1=0 and out2=0, including mid-confirmation and mid-active state.
- Input stage: on each edge, r_rsi <= min(rsi_, RSI_MAX), unsigned compare.
- Classification on r_rsi:
  - below = r_rsi < LOW_TH
  - above = r_rsi > HIGH_TH
  - Values equal to a threshold are not qualifying.
- FSM states: NEUTRAL, PEND_LOW, OVERSOLD, PEND_HIGH, OVERBOUGHT. There is one saturating confirm counter cnt.
- NEUTRAL:
  - below -> cnt=1; go to OVERSOLD if CONFIRM==1, else PEND_LOW.
  - above -> symmetric, to PEND_HIGH or OVERBOUGHT.
  - else stay.
- PEND_LOW:
  - below -> cnt+1; when cnt+1==CONFIRM, go to OVERSOLD.
  - above -> restart as PEND_HIGH with cnt=1.
  - else -> NEUTRAL, cnt=0.
- PEND_HIGH: symmetric to PEND_LOW.
- OVERSOLD:
  - r_rsi >= LOW_TH+HYST -> NEUTRAL; if also above, go directly to PEND_HIGH with cnt=1 (or OVERBOUGHT if CONFIRM==1).
  - otherwise stay.
- OVERBOUGHT: exit when r_rsi <= HIGH_TH-HYST, symmetric to OVERSOLD.
- Outputs: out1 = (state==OVERSOLD); out2 = (state==OVERBOUGHT). They are decoded from the registered state only, are glitch-free, and are never simultaneously 1.
- Latency: a qualifying rsi_ stable before edge E0 asserts its output after edge E0+CONFIRM (3 edges for CONFIRM=2). Deassertion takes 2 edges after a valid exit value is applied.
- Arithmetic: exit thresholds are computed at WIDTH+1 bits with no wrap; HIGH_TH-HYST saturates at 0.
- Parameter constraint: LOW_TH+HYST <= HIGH_TH-HYST is required (checked by elaboration assertion).

Test Plan:
- Reset: hold rst_n=0 with rsi_=10 over many clocks -> out1=0, out2=0. Assert rst_n=0 asynchronously while OVERSOLD -> out1 drops immediately, without a clock edge.
- Oversold entry: rsi_=50 then 20 -> out1=1 exactly 3 edges after 20 is applied, out2=0. Then rsi_=33 -> out1 stays 1 (hysteresis). Then rsi_=35 -> out1=0 after 2 edges.
- Overbought with clamp: rsi_=0xFFFFFFFF -> treated as 100, out2=1 after 3 edges. Then rsi_=66 -> out2 stays 1. Then rsi_=65 -> out2=0.
- Threshold boundaries: rsi_=30 or 70 held 10 cycles -> both outputs 0. rsi_=29 -> out1 asserts. rsi_=71 -> out2 asserts.
- Spike rejection: rsi_ sequence 50, 20 (one cycle), 50 -> out1 never asserts. Sequence 20, 80, 80 -> out2 asserts, out1 never asserts.
- Direct swing: in OVERSOLD apply rsi_=90 -> out1=0 after 2 edges, out2=1 one edge after that. out1 and out2 are never both 1 on any cycle; the bench checks this throughout every scenario.
